// File: rtl/mem_access.sv
// Memory-access pipeline stage: passes ALU/HI-LO results through and runs a
// req/ack data-bus transaction for loads and stores, stalling until it ends.
module mem_access (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_wreg,
  input  logic [4:0]  i_wd,
  input  logic [31:0] i_wdata,
  input  logic        i_whilo,
  input  logic [31:0] i_hi,
  input  logic [31:0] i_lo,
  input  logic [3:0]  i_memop,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_sdata,
  output logic        o_wreg,
  output logic [4:0]  o_wd,
  output logic [31:0] o_wdata,
  output logic        o_whilo,
  output logic [31:0] o_hi,
  output logic [31:0] o_lo,
  output logic        o_excp_align,
  output logic        stallreq,
  output logic        dbus_req,
  output logic        dbus_we,
  output logic [3:0]  dbus_sel,
  output logic [31:0] dbus_addr,
  output logic [31:0] dbus_wdata,
  input  logic [31:0] dbus_rdata,
  input  logic        dbus_ack
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [3:0] OP_LB  = 4'd1;
  localparam logic [3:0] OP_LBU = 4'd2;
  localparam logic [3:0] OP_LH  = 4'd3;
  localparam logic [3:0] OP_LHU = 4'd4;
  localparam logic [3:0] OP_LW  = 4'd5;
  localparam logic [3:0] OP_SB  = 4'd6;
  localparam logic [3:0] OP_SH  = 4'd7;
  localparam logic [3:0] OP_SW  = 4'd8;

  state_t      state_q, state_d;
  logic        req_q, req_d;
  logic        we_q, we_d;
  logic [3:0]  sel_q, sel_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdataBus_q, wdataBus_d;
  logic [31:0] rdata_q, rdata_d;

  logic        isLoad, isStore, isByte, isHalf, isWord;
  logic        misaligned, memAligned;
  logic [3:0]  laneSel;
  logic [31:0] storeData;
  logic [7:0]  loadByte;
  logic [15:0] loadHalf;
  logic [31:0] loadValue;

  always_comb begin
    isLoad  = 1'b0;
    isStore = 1'b0;
    isByte  = 1'b0;
    isHalf  = 1'b0;
    isWord  = 1'b0;
    case (i_memop)
      OP_LB, OP_LBU: begin isLoad  = 1'b1; isByte = 1'b1; end
      OP_LH, OP_LHU: begin isLoad  = 1'b1; isHalf = 1'b1; end
      OP_LW:         begin isLoad  = 1'b1; isWord = 1'b1; end
      OP_SB:         begin isStore = 1'b1; isByte = 1'b1; end
      OP_SH:         begin isStore = 1'b1; isHalf = 1'b1; end
      OP_SW:         begin isStore = 1'b1; isWord = 1'b1; end
      default:       ;
    endcase
    misaligned = (isHalf && i_addr[0]) || (isWord && (i_addr[1:0] != 2'b00));
    memAligned = (isLoad || isStore) && !misaligned;
  end

  // Big-endian lanes: byte offset 0 lives in bits 31:24.
  always_comb begin
    laneSel   = 4'b0000;
    storeData = i_sdata;
    if (isByte) begin
      laneSel   = 4'b1000 >> i_addr[1:0];
      storeData = {4{i_sdata[7:0]}};
    end else if (isHalf) begin
      laneSel   = i_addr[1] ? 4'b0011 : 4'b1100;
      storeData = {2{i_sdata[15:0]}};
    end else if (isWord) begin
      laneSel   = 4'b1111;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      sel_q      <= 4'b0000;
      addr_q     <= 32'h0;
      wdataBus_q <= 32'h0;
      rdata_q    <= 32'h0;
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      we_q       <= we_d;
      sel_q      <= sel_d;
      addr_q     <= addr_d;
      wdataBus_q <= wdataBus_d;
      rdata_q    <= rdata_d;
    end
  end

  // Ack is only honoured in BUSY; address and store data simply hold afterwards.
  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    we_d       = we_q;
    sel_d      = sel_q;
    addr_d     = addr_q;
    wdataBus_d = wdataBus_q;
    rdata_d    = rdata_q;
    case (state_q)
      IDLE: begin
        if (memAligned) begin
          state_d    = BUSY;
          req_d      = 1'b1;
          we_d       = isStore;
          sel_d      = laneSel;
          addr_d     = {i_addr[31:2], 2'b00};
          wdataBus_d = storeData;
        end
      end
      BUSY: begin
        if (dbus_ack) begin
          state_d = DONE;
          rdata_d = dbus_rdata;
          req_d   = 1'b0;
          we_d    = 1'b0;
          sel_d   = 4'b0000;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    case (i_addr[1:0])
      2'd0:    loadByte = rdata_q[31:24];
      2'd1:    loadByte = rdata_q[23:16];
      2'd2:    loadByte = rdata_q[15:8];
      default: loadByte = rdata_q[7:0];
    endcase
    loadHalf = i_addr[1] ? rdata_q[15:0] : rdata_q[31:16];
    case (i_memop)
      OP_LB:   loadValue = {{24{loadByte[7]}}, loadByte};
      OP_LBU:  loadValue = {24'h0, loadByte};
      OP_LH:   loadValue = {{16{loadHalf[15]}}, loadHalf};
      OP_LHU:  loadValue = {16'h0, loadHalf};
      default: loadValue = rdata_q;
    endcase
  end

  // o_wreg stays low until DONE so a stalled MEM/WB capture never commits stale data.
  always_comb begin
    o_wreg       = i_wreg;
    o_wd         = i_wd;
    o_wdata      = i_wdata;
    o_whilo      = i_whilo;
    o_hi         = i_hi;
    o_lo         = i_lo;
    o_excp_align = 1'b0;
    stallreq     = 1'b0;
    if (rst) begin
      o_wreg  = 1'b0;
      o_wd    = 5'd0;
      o_wdata = 32'h0;
      o_whilo = 1'b0;
      o_hi    = 32'h0;
      o_lo    = 32'h0;
    end else if (misaligned) begin
      o_wreg       = 1'b0;
      o_excp_align = 1'b1;
    end else if (memAligned) begin
      case (state_q)
        IDLE, BUSY: begin
          o_wreg   = 1'b0;
          stallreq = 1'b1;
        end
        DONE: begin
          if (isStore) o_wreg = 1'b0;
          else o_wdata = loadValue;
        end
        default: ;
      endcase
    end
  end

  assign dbus_req   = req_q;
  assign dbus_we    = we_q;
  assign dbus_sel   = sel_q;
  assign dbus_addr  = addr_q;
  assign dbus_wdata = wdataBus_q;

endmodule

// File: tb/tb_mem_access.sv
// Self-checking bench for mem_access: a transaction-level model predicts every
// output each cycle; a few hand-computed literals pin the model down.
module tb_mem_access;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_wreg;
  logic [4:0]  i_wd;
  logic [31:0] i_wdata;
  logic        i_whilo;
  logic [31:0] i_hi, i_lo;
  logic [3:0]  i_memop;
  logic [31:0] i_addr, i_sdata;
  logic        o_wreg;
  logic [4:0]  o_wd;
  logic [31:0] o_wdata;
  logic        o_whilo;
  logic [31:0] o_hi, o_lo;
  logic        o_excp_align, stallreq;
  logic        dbus_req, dbus_we;
  logic [3:0]  dbus_sel;
  logic [31:0] dbus_addr, dbus_wdata, dbus_rdata;
  logic        dbus_ack;

  mem_access dut (
    .clk(clk), .rst(rst),
    .i_wreg(i_wreg), .i_wd(i_wd), .i_wdata(i_wdata),
    .i_whilo(i_whilo), .i_hi(i_hi), .i_lo(i_lo),
    .i_memop(i_memop), .i_addr(i_addr), .i_sdata(i_sdata),
    .o_wreg(o_wreg), .o_wd(o_wd), .o_wdata(o_wdata),
    .o_whilo(o_whilo), .o_hi(o_hi), .o_lo(o_lo),
    .o_excp_align(o_excp_align), .stallreq(stallreq),
    .dbus_req(dbus_req), .dbus_we(dbus_we), .dbus_sel(dbus_sel),
    .dbus_addr(dbus_addr), .dbus_wdata(dbus_wdata),
    .dbus_rdata(dbus_rdata), .dbus_ack(dbus_ack)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  bit          expValid = 1'b0;
  logic        expWreg, expWhilo, expExcp, expStall;
  logic [4:0]  expWd;
  logic [31:0] expWdata, expHi, expLo;
  bit          chkBus, chkAddr;
  logic        expReq, expWe;
  logic [3:0]  expSel;
  logic [31:0] expAddr, expBusW;

  logic [3:0]  sawSel;
  logic [31:0] sawAddr, sawBusW, sawDoneWdata;
  logic        sawWe;
  int          stallCount, wregHighCount;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (expValid) begin
      checkOutput("o_wreg", 32'(o_wreg), 32'(expWreg));
      checkOutput("o_wd", 32'(o_wd), 32'(expWd));
      checkOutput("o_wdata", o_wdata, expWdata);
      checkOutput("o_whilo", 32'(o_whilo), 32'(expWhilo));
      checkOutput("o_hi", o_hi, expHi);
      checkOutput("o_lo", o_lo, expLo);
      checkOutput("o_excp_align", 32'(o_excp_align), 32'(expExcp));
      checkOutput("stallreq", 32'(stallreq), 32'(expStall));
      if (chkBus) begin
        checkOutput("dbus_req", 32'(dbus_req), 32'(expReq));
        checkOutput("dbus_we", 32'(dbus_we), 32'(expWe));
        checkOutput("dbus_sel", 32'(dbus_sel), 32'(expSel));
      end
      if (chkAddr) begin
        checkOutput("dbus_addr", dbus_addr, expAddr);
        checkOutput("dbus_wdata", dbus_wdata, expBusW);
      end
    end
  end

  // Size in bytes of the access (0 = not a memory op); loads are codes 1..5.
  function automatic int opSize(input logic [3:0] op);
    case (op)
      4'd1, 4'd2, 4'd6: return 1;
      4'd3, 4'd4, 4'd7: return 2;
      4'd5, 4'd8:       return 4;
      default:          return 0;
    endcase
  endfunction

  function automatic logic [31:0] loadResult(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] rdata);
    int off;
    logic [31:0] v;
    off = int'(addr % 4);
    case (opSize(op))
      1: begin
        v = (rdata >> (8 * (3 - off))) & 32'hFF;
        if (op == 4'd1 && v >= 32'd128) v = v | 32'hFFFFFF00;
      end
      2: begin
        v = (rdata >> (8 * (2 - off))) & 32'hFFFF;
        if (op == 4'd3 && v >= 32'd32768) v = v | 32'hFFFF0000;
      end
      default: v = rdata;
    endcase
    return v;
  endfunction

  task automatic modelCycle(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] sdata,
                            input logic [31:0] rdata, input logic wreg, input logic [4:0] wd,
                            input logic [31:0] wdata, input int ackAt, input int k);
    int size, off;
    bit isLoad, isStore, misal, mem, busy, done;
    size    = opSize(op);
    off     = int'(addr % 4);
    isLoad  = (op >= 4'd1 && op <= 4'd5);
    isStore = (op >= 4'd6 && op <= 4'd8);
    misal   = (size > 0) && ((off % size) != 0);
    mem     = (size > 0) && !misal;
    busy    = mem && k >= 1 && k <= ackAt;
    done    = mem && k == ackAt + 1;
    expWd    = wd;
    expWhilo = i_whilo;
    expHi    = i_hi;
    expLo    = i_lo;
    expExcp  = misal;
    expStall = mem && k <= ackAt;
    expWreg  = misal ? 1'b0 : (mem ? (done && isLoad && wreg) : wreg);
    expWdata = (done && isLoad) ? loadResult(op, addr, rdata) : wdata;
    chkBus   = 1'b1;
    expReq   = busy;
    expWe    = busy && isStore;
    expSel   = 4'b0000;
    if (busy) begin
      if (size == 1) expSel = 4'(4'b1000 >> off);
      else if (size == 2) expSel = 4'(4'b1100 >> off);
      else expSel = 4'b1111;
    end
    chkAddr = busy;
    expAddr = addr - 32'(off);
    if (size == 1) expBusW = (sdata & 32'hFF) * 32'h01010101;
    else if (size == 2) expBusW = (sdata & 32'hFFFF) * 32'h00010001;
    else expBusW = sdata;
  endtask

  task automatic driveInputs(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] sdata,
                             input logic wreg, input logic [4:0] wd, input logic [31:0] wdata);
    i_memop = op;
    i_addr  = addr;
    i_sdata = sdata;
    i_wreg  = wreg;
    i_wd    = wd;
    i_wdata = wdata;
    i_whilo = wd[0];
    i_hi    = ~wdata;
    i_lo    = wdata ^ 32'h5A5A5A5A;
  endtask

  // One operation from presentation through DONE; ack is driven in cycle ackAt.
  task automatic applyStimulus(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] sdata,
                               input logic [31:0] rdata, input logic wreg, input logic [4:0] wd,
                               input logic [31:0] wdata, input int ackAt);
    int size, nCyc;
    bit mem;
    size = opSize(op);
    mem  = (size > 0) && ((addr % 32'(size)) == 0);
    nCyc = mem ? ackAt + 2 : 1;
    stallCount = 0;
    wregHighCount = 0;
    sawSel = 4'hF;
    sawAddr = 32'hFFFFFFFF;
    sawBusW = 32'hFFFFFFFF;
    sawWe = 1'b0;
    for (int k = 0; k < nCyc; k++) begin
      driveInputs(op, addr, sdata, wreg, wd, wdata);
      dbus_ack   = mem && (k == ackAt);
      dbus_rdata = dbus_ack ? rdata : 32'h0BAD0BAD;
      modelCycle(op, addr, sdata, rdata, wreg, wd, wdata, ackAt, k);
      expValid = 1'b1;
      @(negedge clk);
      if (stallreq) stallCount++;
      if (o_wreg) wregHighCount++;
      if (k == 1) begin
        sawSel  = dbus_sel;
        sawAddr = dbus_addr;
        sawBusW = dbus_wdata;
        sawWe   = dbus_we;
      end
      if (k == nCyc - 1) sawDoneWdata = o_wdata;
      @(posedge clk);
      #1;
    end
    dbus_ack = 1'b0;
  endtask

  task automatic expectResetCycle(input bit busKnown);
    expWreg = 1'b0; expWd = 5'd0; expWdata = 32'h0; expWhilo = 1'b0;
    expHi = 32'h0; expLo = 32'h0; expExcp = 1'b0; expStall = 1'b0;
    chkBus = busKnown; expReq = 1'b0; expWe = 1'b0; expSel = 4'b0000;
    chkAddr = busKnown; expAddr = 32'h0; expBusW = 32'h0;
    expValid = 1'b1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired actual=running required=finished");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst = 1'b1;
    dbus_ack = 1'b0;
    dbus_rdata = 32'h0;
    driveInputs(4'd0, 32'h0, 32'h0, 1'b1, 5'd7, 32'hDEADBEEF);
    @(posedge clk); #1;
    for (int r = 0; r < 2; r++) begin
      expectResetCycle(1'b1);
      @(posedge clk); #1;
    end
    rst = 1'b0;

    // ALU pass-through
    applyStimulus(4'd0, 32'h0, 32'h0, 32'h0, 1'b1, 5'd5, 32'h00001234, 0);
    checkOutput("lit_pass_wdata", sawDoneWdata, 32'h00001234);
    applyStimulus(4'd12, 32'h3, 32'h0, 32'h0, 1'b1, 5'd9, 32'h87654321, 0);

    // LB / LBU sign and zero extension, ack in first BUSY cycle
    applyStimulus(4'd1, 32'h101, 32'h0, 32'h11F02233, 1'b1, 5'd3, 32'hAAAA0000, 1);
    checkOutput("lit_lb_wdata", sawDoneWdata, 32'hFFFFFFF0);
    checkOutput("lit_lb_sel", 32'(sawSel), 32'h4);
    checkOutput("lit_lb_addr", sawAddr, 32'h100);
    checkOutput("lit_lb_stall", 32'(stallCount), 32'd2);
    applyStimulus(4'd2, 32'h101, 32'h0, 32'h11F02233, 1'b1, 5'd3, 32'hAAAA0000, 1);
    checkOutput("lit_lbu_wdata", sawDoneWdata, 32'h000000F0);

    // SH with 3-cycle ack delay
    applyStimulus(4'd7, 32'h202, 32'hABCD5678, 32'h0, 1'b1, 5'd4, 32'h00000202, 3);
    checkOutput("lit_sh_we", 32'(sawWe), 32'd1);
    checkOutput("lit_sh_sel", 32'(sawSel), 32'h3);
    checkOutput("lit_sh_wdata", sawBusW, 32'h56785678);
    checkOutput("lit_sh_stall", 32'(stallCount), 32'd4);
    checkOutput("lit_sh_wreg", 32'(wregHighCount), 32'd0);

    // Further lanes: LH sign-extend at offset 2, SB, SW, LW
    applyStimulus(4'd3, 32'h302, 32'h0, 32'h1234F00D, 1'b1, 5'd6, 32'h0, 2);
    checkOutput("lit_lh_wdata", sawDoneWdata, 32'hFFFFF00D);
    applyStimulus(4'd6, 32'h303, 32'h000000A5, 32'h0, 1'b1, 5'd8, 32'h0, 1);
    applyStimulus(4'd8, 32'h308, 32'hCAFEF00D, 32'h0, 1'b1, 5'd8, 32'h0, 2);

    // Misaligned accesses
    applyStimulus(4'd5, 32'h3, 32'h0, 32'h0, 1'b1, 5'd2, 32'h55AA55AA, 1);
    checkOutput("lit_misal_wreg", 32'(wregHighCount), 32'd0);
    applyStimulus(4'd7, 32'h205, 32'h1111, 32'h0, 1'b1, 5'd2, 32'h0, 1);

    // Reset during BUSY, then late acks that must be ignored
    driveInputs(4'd5, 32'h500, 32'h0, 1'b1, 5'd10, 32'h13572468);
    dbus_ack = 1'b0;
    for (int k = 0; k < 2; k++) begin
      modelCycle(4'd5, 32'h500, 32'h0, 32'h0, 1'b1, 5'd10, 32'h13572468, 10, k);
      expValid = 1'b1;
      @(posedge clk); #1;
    end
    rst = 1'b1;
    expectResetCycle(1'b0);
    @(posedge clk); #1;
    dbus_ack = 1'b1;
    dbus_rdata = 32'hCAFEBABE;
    expectResetCycle(1'b1);
    @(posedge clk); #1;
    rst = 1'b0;
    driveInputs(4'd0, 32'h0, 32'h0, 1'b1, 5'd11, 32'h00C0FFEE);
    modelCycle(4'd0, 32'h0, 32'h0, 32'h0, 1'b1, 5'd11, 32'h00C0FFEE, 0, 0);
    @(posedge clk); #1;
    dbus_ack = 1'b0;
    applyStimulus(4'd5, 32'h504, 32'h0, 32'h89ABCDEF, 1'b1, 5'd12, 32'h0, 1);
    checkOutput("lit_lw_after_rst", sawDoneWdata, 32'h89ABCDEF);

    // Back-to-back loads with no gap
    applyStimulus(4'd4, 32'h400, 32'h0, 32'h1234ABCD, 1'b1, 5'd13, 32'h0, 1);
    checkOutput("lit_lhu_wdata", sawDoneWdata, 32'h00001234);
    applyStimulus(4'd5, 32'h404, 32'h0, 32'hDEADBEEF, 1'b1, 5'd14, 32'h0, 2);
    checkOutput("lit_lw_b2b", sawDoneWdata, 32'hDEADBEEF);

    applyStimulus(4'd0, 32'h0, 32'h0, 32'h0, 1'b0, 5'd1, 32'h0F0F0F0F, 0);
    expValid = 1'b0;
    @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
